// File: rtl/idm_pkg.sv
// Shared definitions for the idm loader block.
//   ADR_W / DATA_W / RD_W : default widths of the idm address, write data
//                           and read data buses
//   state_t               : job controller states
package idm_pkg;

    localparam int ADR_W  = 8;
    localparam int DATA_W = 8;
    localparam int RD_W   = 14;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/idm_adr_ctr.sv
// Address generator for the idm loader.
// Holds the job base address and length, an offset counter with
// clear/increment, and produces the wrapping memory address plus a flag
// that marks the final offset of the job.
//   clk      : clock
//   reset    : synchronous active-high reset
//   i_latch  : capture i_base / i_len for a new job
//   i_base   : first memory address of the job
//   i_len    : byte count of the job
//   i_clr    : clear the offset (wins over i_inc)
//   i_inc    : advance the offset by one
//   o_adr    : base + offset, wrapping modulo 2^ADR_W
//   o_last   : offset equals len-1
module idm_adr_ctr #(
    parameter int ADR_W = idm_pkg::ADR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_latch,
    input  logic [ADR_W-1:0] i_base,
    input  logic [ADR_W-1:0] i_len,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [ADR_W-1:0] o_adr,
    output logic             o_last
);

    logic [ADR_W-1:0] r_base;
    logic [ADR_W-1:0] r_len;
    logic [ADR_W-1:0] r_offset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base   <= '0;
            r_len    <= '0;
            r_offset <= '0;
        end else begin
            if (i_latch) begin
                r_base <= i_base;
                r_len  <= i_len;
            end
            if (i_clr) begin
                r_offset <= '0;
            end else if (i_inc) begin
                r_offset <= r_offset + ADR_W'(1);
            end
        end
    end

    // Natural-width addition gives the modulo-2^ADR_W wrap for free.
    assign o_adr  = r_base + r_offset;
    assign o_last = (r_offset == (r_len - ADR_W'(1)));

endmodule

// File: rtl/idm_loader.sv
// Load-and-verify engine for the idm memory.
// On start it streams len bytes into memory at base_adr.., summing them,
// then reads the same addresses back, sums the low DATA_W bits of each
// read, and finishes in DONE when both sums agree or ERROR otherwise.
//   clk, reset            : clock, synchronous active-high reset
//   start, base_adr, len  : job request (accepted in IDLE/DONE/ERROR)
//   in_valid, in_data     : byte stream in; in_ready high while loading
//   memWrite, adr, WD     : idm write port / shared address
//   rdata                 : idm read data, combinational from adr
//   busy, done, error     : job status levels
//   checksum              : running mod-2^DATA_W sum of loaded bytes
module idm_loader #(
    parameter int ADR_W  = idm_pkg::ADR_W,
    parameter int DATA_W = idm_pkg::DATA_W,
    parameter int RD_W   = idm_pkg::RD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADR_W-1:0]  base_adr,
    input  logic [ADR_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              memWrite,
    output logic [ADR_W-1:0]  adr,
    output logic [DATA_W-1:0] WD,
    input  logic [RD_W-1:0]   rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    import idm_pkg::*;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_lsum;
    logic [DATA_W-1:0] r_vsum;
    logic [DATA_W-1:0] r_wd;

    logic              w_accept;
    logic              w_hs;
    logic              w_latch;
    logic              w_clr;
    logic              w_inc;
    logic              w_last;
    logic [DATA_W-1:0] w_rbyte;
    logic [DATA_W-1:0] w_vsum_final;

    // Only the low byte of the read bus takes part in verification.
    assign w_rbyte = rdata[DATA_W-1:0];

    generate
        if (RD_W > DATA_W) begin : g_rd_upper
            logic w_unused_rd_upper;
            assign w_unused_rd_upper = ^rdata[RD_W-1:DATA_W];
        end
    endgenerate

    assign w_accept     = start && (r_state == IDLE || r_state == DONE || r_state == ERROR);
    assign w_hs         = (r_state == LOAD) && in_valid;
    assign w_vsum_final = r_vsum + w_rbyte;

    idm_adr_ctr #(
        .ADR_W (ADR_W)
    ) u_adr_ctr (
        .clk     (clk),
        .reset   (reset),
        .i_latch (w_latch),
        .i_base  (base_adr),
        .i_len   (len),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_adr   (adr),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_clr        = 1'b0;
        w_inc        = 1'b0;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (w_accept) begin
                    // An empty job completes immediately without touching
                    // the address counter, so adr keeps its last value.
                    if (len == '0) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = LOAD;
                        w_latch      = 1'b1;
                        w_clr        = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_state_next = VERIFY;
                        w_clr        = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            VERIFY: begin
                // The offset stops on the final read so adr keeps pointing
                // at the last accessed location while DONE/ERROR is held.
                if (w_last) begin
                    w_state_next = (w_vsum_final == r_lsum) ? DONE : ERROR;
                end else begin
                    w_inc = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lsum <= '0;
            r_vsum <= '0;
            r_wd   <= '0;
        end else if (w_accept) begin
            r_lsum <= '0;
            r_vsum <= '0;
        end else if (w_hs) begin
            r_lsum <= r_lsum + in_data;
            r_wd   <= in_data;
        end else if (r_state == VERIFY) begin
            r_vsum <= w_vsum_final;
        end
    end

    // Reset gates the strobes combinationally so nothing is written or
    // accepted in the cycle a job is aborted.
    assign in_ready = (r_state == LOAD) && !reset;
    assign memWrite = w_hs && !reset;
    assign WD       = (r_state == LOAD) ? in_data : r_wd;
    assign busy     = (r_state == LOAD) || (r_state == VERIFY);
    assign done     = (r_state == DONE);
    assign error    = (r_state == ERROR);
    assign checksum = r_lsum;

endmodule

// File: doc/idm_loader.md
IDM_LOADER -- requirements
Module: idm_loader

Interface
REQ-001 Parameter ADR_W, default 8, SHALL set the memory address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the write-data and input byte width.
REQ-003 Parameter RD_W, default 14, SHALL set the memory read-data width.
REQ-004 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 start  input  1  SHALL request a load-and-verify job; it is sampled only in IDLE, DONE or ERROR.
REQ-007 base_adr  input  ADR_W  SHALL give the first memory address; it is latched on an accepted start.
REQ-008 len  input  ADR_W  SHALL give the byte count; it is latched on an accepted start, and 0 means an empty job.
REQ-009 in_valid / in_data  input  1 / DATA_W  SHALL carry the byte stream to be loaded.
REQ-010 in_ready  output  1  SHALL be the byte-stream acceptance signal.
REQ-011 memWrite / adr / WD  output  1 / ADR_W / DATA_W  SHALL drive the idm write port.
REQ-012 rdata  input  RD_W  SHALL be the idm out bus, read asynchronously from adr.
REQ-013 busy / done / error  output  1 each  SHALL be the job status flags.
REQ-014 checksum  output  DATA_W  SHALL be the mod-256 sum of the bytes loaded.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, VERIFY, DONE and ERROR.
REQ-016 start in IDLE/DONE/ERROR with len!=0 SHALL, on the next edge, move to LOAD, latch base/len, and clear offset, lsum, vsum, done and error.
REQ-017 start with len==0 SHALL move to DONE on the next edge, with checksum=0 and no memory access.
REQ-018 In LOAD, in_ready SHALL be 1; in all other states and during reset, in_ready SHALL be 0.
REQ-019 In LOAD, memWrite SHALL equal in_valid & ~reset (combinational), with adr = base+offset mod 2^ADR_W and WD = in_data.
REQ-020 Each LOAD handshake SHALL increment offset and add in_data to lsum mod 2^DATA_W; cycles without in_valid SHALL change nothing.
REQ-021 The handshake at offset len-1 SHALL move the FSM to VERIFY with offset cleared.
REQ-022 In VERIFY, memWrite SHALL be 0 and adr SHALL be base+offset; each cycle SHALL add rdata[DATA_W-1:0] to vsum and increment offset.
REQ-023 After the read at offset len-1, the FSM SHALL compare the final vsum to lsum and enter DONE if equal, otherwise ERROR.
REQ-024 Latency: with no stalls, DONE/ERROR SHALL be entered 2*len+1 edges after the start edge.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADR_W (base 0xFE, len 4 -> FE, FF, 00, 01).
REQ-026 busy SHALL be 1 exactly in LOAD and VERIFY.
REQ-027 done and error SHALL be levels held in their state until the next accepted start or reset.
REQ-028 start asserted while busy SHALL be ignored and SHALL NOT alter the job in progress.
REQ-029 checksum SHALL show lsum continuously and hold its value in DONE/ERROR.
REQ-030 Outside LOAD, memWrite SHALL be 0, and adr SHALL hold base+offset of the last access.

Reset
REQ-031 reset SHALL, at the next edge, force IDLE with offset, lsum, vsum, base and len at 0 and busy, done and error at 0.
REQ-032 After reset, adr, WD and checksum SHALL be 0.
REQ-033 Reset mid-LOAD or mid-VERIFY SHALL abort the job, perform no write in the reset cycle, and require a new start.
REQ-034 reset SHALL take priority over start and in_valid in the same cycle.

Structure
REQ-035 A shared package idm_pkg SHALL hold the state enum (IDLE, LOAD, VERIFY, DONE, ERROR) and the widths ADR_W=8, DATA_W=8 and RD_W=14.
REQ-036 One sub-module, idm_adr_ctr, SHALL contain the latched base, the offset counter with clear/increment, the wrapping adr output and the last-offset flag.
REQ-037 The checksum accumulators and the FSM SHALL stay in idm_loader.

Verification
REQ-038 The bench SHALL cover reset, then start with base=0x10, len=3 and bytes 0x01/0x02/0x03 every cycle -> writes to 0x10..0x12, checksum=0x06, and done=1 seven edges after start.
REQ-039 The bench SHALL cover in_valid gapped (1,0,0,1,1) with len=3 -> exactly 3 memWrite pulses, no write on gap cycles, and done=1.
REQ-040 The bench SHALL cover base=0xFE, len=4 -> write addresses FE, FF, 00, 01, and VERIFY reads the same order.
REQ-041 The bench SHALL cover an idm model that corrupts address 0x11 to 0x07 -> error=1, done=0, checksum=0x06.
REQ-042 The bench SHALL cover len=0 -> done=1 one edge after start, with memWrite never asserted.
REQ-043 The bench SHALL cover reset asserted after the 2nd LOAD byte -> IDLE, busy=0, no further writes, and a fresh start completing normally.
